// File: rtl/bp_pkg.sv
// Shared helpers for the branch target buffer: PC field extraction and
// saturating direction-counter arithmetic, all parameterised by width.
package bp_pkg;

  function automatic int unsigned cnt_max(input int unsigned cnt_w);
    return (32'd1 << cnt_w) - 32'd1;
  endfunction

  function automatic int unsigned cnt_weak_t(input int unsigned cnt_w);
    return 32'd1 << (cnt_w - 32'd1);
  endfunction

  function automatic int unsigned cnt_weak_nt(input int unsigned cnt_w);
    return (32'd1 << (cnt_w - 32'd1)) - 32'd1;
  endfunction

  // Word-aligned PCs: bits [1:0] never take part in index or tag.
  function automatic logic [63:0] pc_index(input logic [63:0] pc, input int unsigned idx_w);
    return (pc >> 2) & ((64'd1 << idx_w) - 64'd1);
  endfunction

  function automatic logic [63:0] pc_tag(input logic [63:0] pc, input int unsigned idx_w);
    return pc >> (idx_w + 2);
  endfunction

  function automatic logic [3:0] sat_step(input logic [3:0] cnt, input logic up,
                                          input int unsigned cnt_w);
    if (up) return (32'(cnt) == cnt_max(cnt_w)) ? cnt : cnt + 4'd1;
    else    return (cnt == 4'd0) ? cnt : cnt - 4'd1;
  endfunction

endpackage

// File: rtl/branch_predictor_btb_if.sv
// Fetch-side lookup and MEM-side resolution signals of the BTB.
interface branch_predictor_btb_if #(parameter int ADDR_W = 32);
    logic [ADDR_W-1:0] lookup_pc;
    logic              pred_hit;
    logic              pred_taken;
    logic [ADDR_W-1:0] pred_target;
    logic              upd_valid;
    logic [ADDR_W-1:0] upd_pc;
    logic              upd_taken;
    logic [ADDR_W-1:0] upd_target;
    logic              upd_mispredict;
    logic              inv_all;

    modport master (
        output lookup_pc, upd_valid, upd_pc, upd_taken, upd_target, upd_mispredict, inv_all,
        input  pred_hit, pred_taken, pred_target
    );

    modport slave (
        input  lookup_pc, upd_valid, upd_pc, upd_taken, upd_target, upd_mispredict, inv_all,
        output pred_hit, pred_taken, pred_target
    );
endinterface

// File: rtl/bp_sat_counter.sv
// Per-entry saturating direction counter: reset to weakly not-taken,
// load to weakly taken on allocation, otherwise step up or down.
module bp_sat_counter
    import bp_pkg::*;
#(
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             dec,
    input  logic             load,
    output logic [CNT_W-1:0] cnt
);
    localparam logic [CNT_W-1:0] WEAK_T  = CNT_W'(cnt_weak_t(CNT_W));
    localparam logic [CNT_W-1:0] WEAK_NT = CNT_W'(cnt_weak_nt(CNT_W));

    always_ff @(posedge clk) begin
        if (reset)     cnt <= WEAK_NT;
        else if (load) cnt <= WEAK_T;
        else if (inc)  cnt <= CNT_W'(sat_step(4'(cnt), 1'b1, CNT_W));
        else if (dec)  cnt <= CNT_W'(sat_step(4'(cnt), 1'b0, CNT_W));
    end
endmodule

// File: rtl/branch_predictor_btb.sv
// Direct-mapped BTB with per-entry saturating direction counters.
// Optional statistics counters are built when BP_STATS_EN is defined.
module branch_predictor_btb
    import bp_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int IDX_W  = 4,
    parameter int CNT_W  = 2,
    parameter int TAG_W  = ADDR_W - IDX_W - 2
) (
    input  logic clk,
    input  logic reset,
    branch_predictor_btb_if.slave bus
`ifdef BP_STATS_EN
    ,
    output logic [31:0] stat_updates,
    output logic [31:0] stat_mispredicts
`endif
);
    localparam int ENTRIES = 2 ** IDX_W;

    logic [ENTRIES-1:0]             valid;
    logic [ENTRIES-1:0][TAG_W-1:0]  tag;
    logic [ENTRIES-1:0][ADDR_W-1:0] target;
    logic [ENTRIES-1:0][CNT_W-1:0]  cnt;

    logic [IDX_W-1:0] lk_idx, up_idx;
    logic [TAG_W-1:0] lk_tag, up_tag;
    logic             lk_hit, up_hit, upd_act;
    logic [ENTRIES-1:0] cnt_inc, cnt_dec, cnt_load;

    assign lk_idx = IDX_W'(pc_index(64'(bus.lookup_pc), IDX_W));
    assign lk_tag = TAG_W'(pc_tag(64'(bus.lookup_pc), IDX_W));
    assign up_idx = IDX_W'(pc_index(64'(bus.upd_pc), IDX_W));
    assign up_tag = TAG_W'(pc_tag(64'(bus.upd_pc), IDX_W));

    // Lookup sees pre-update state; no bypass from the update port.
    assign lk_hit          = valid[lk_idx] && (tag[lk_idx] == lk_tag);
    assign bus.pred_hit    = lk_hit;
    assign bus.pred_taken  = lk_hit & cnt[lk_idx][CNT_W-1];
    assign bus.pred_target = lk_hit ? target[lk_idx] : '0;

    assign up_hit  = valid[up_idx] && (tag[up_idx] == up_tag);
    assign upd_act = bus.upd_valid & ~bus.inv_all;

    always_comb begin
        cnt_inc  = '0;
        cnt_dec  = '0;
        cnt_load = '0;
        if (upd_act) begin
            cnt_inc[up_idx]  = up_hit & bus.upd_taken;
            cnt_dec[up_idx]  = up_hit & ~bus.upd_taken;
            cnt_load[up_idx] = ~up_hit & bus.upd_taken;
        end
    end

    for (genvar g = 0; g < ENTRIES; g++) begin : g_ent
        bp_sat_counter #(.CNT_W(CNT_W)) u_cnt (
            .clk   (clk),
            .reset (reset),
            .inc   (cnt_inc[g]),
            .dec   (cnt_dec[g]),
            .load  (cnt_load[g]),
            .cnt   (cnt[g])
        );
    end

    // Not-taken resolutions only move the counter; a not-taken miss allocates nothing.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid  <= '0;
            tag    <= '0;
            target <= '0;
        end else if (bus.inv_all) begin
            valid  <= '0;
        end else if (bus.upd_valid && bus.upd_taken) begin
            target[up_idx] <= bus.upd_target;
            if (!up_hit) begin
                valid[up_idx] <= 1'b1;
                tag[up_idx]   <= up_tag;
            end
        end
    end

`ifdef BP_STATS_EN
    // Counted per resolved cycle, independent of inv_all.
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_updates     <= '0;
            stat_mispredicts <= '0;
        end else if (bus.upd_valid) begin
            if (stat_updates != '1) stat_updates <= stat_updates + 32'd1;
            if (bus.upd_mispredict && stat_mispredicts != '1)
                stat_mispredicts <= stat_mispredicts + 32'd1;
        end
    end
`else
    logic unused_mispredict;
    assign unused_mispredict = bus.upd_mispredict;
`endif
endmodule

// File: tb/tb_branch_predictor_btb.sv
// Scoreboard bench: each stimulus cycle pushes the model's prediction, a
// negedge monitor pops and compares it against the DUT outputs.
module tb_branch_predictor_btb;
    localparam int ADDR_W = 32, IDX_W = 4, CNT_W = 2, ENTRIES = 16;
    localparam int CMAX = 3, WEAK_T = 2, WEAK_NT = 1;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    branch_predictor_btb_if #(.ADDR_W(ADDR_W)) bus ();
`ifdef BP_STATS_EN
    logic [31:0] stat_u, stat_m;
`endif

    branch_predictor_btb #(.ADDR_W(ADDR_W), .IDX_W(IDX_W), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
`ifdef BP_STATS_EN
        ,
        .stat_updates     (stat_u),
        .stat_mispredicts (stat_m)
`endif
    );

    typedef struct {
        logic        hit;
        logic        taken;
        logic [31:0] tgt;
    } exp_t;
    exp_t q[$];

    int checks = 0;
    int errors = 0;

    // Reference model: one record per set, plain integer counter.
    bit          m_valid[ENTRIES];
    int unsigned m_tag[ENTRIES];
    logic [31:0] m_tgt[ENTRIES];
    int          m_cnt[ENTRIES];
    longint      m_upd, m_mis;

    function automatic void model_reset();
        for (int i = 0; i < ENTRIES; i++) begin
            m_valid[i] = 0; m_tag[i] = 0; m_tgt[i] = 0; m_cnt[i] = WEAK_NT;
        end
        m_upd = 0; m_mis = 0;
    endfunction

    task automatic step(input logic [31:0] lpc, input bit uv, input logic [31:0] upc,
                        input bit ut, input logic [31:0] utg, input bit um,
                        input bit inv, input bit rst);
        exp_t e;
        int li, ui;
        int unsigned lt, ut_tag;
        bus.lookup_pc = lpc; bus.upd_valid = uv; bus.upd_pc = upc; bus.upd_taken = ut;
        bus.upd_target = utg; bus.upd_mispredict = um; bus.inv_all = inv; reset = rst;
        li = (lpc / 4) % ENTRIES;  lt = lpc / (4 * ENTRIES);
        ui = (upc / 4) % ENTRIES;  ut_tag = upc / (4 * ENTRIES);
        e.hit   = m_valid[li] && m_tag[li] == lt;
        e.taken = e.hit && m_cnt[li] >= WEAK_T;
        e.tgt   = e.hit ? m_tgt[li] : 32'd0;
        q.push_back(e);
        if (rst) model_reset();
        else begin
            if (uv) begin
                if (m_upd < 64'hFFFF_FFFF) m_upd++;
                if (um && m_mis < 64'hFFFF_FFFF) m_mis++;
            end
            if (inv) begin
                for (int i = 0; i < ENTRIES; i++) m_valid[i] = 0;
            end else if (uv) begin
                if (m_valid[ui] && m_tag[ui] == ut_tag) begin
                    if (ut) begin
                        m_cnt[ui] = (m_cnt[ui] + 1 > CMAX) ? CMAX : m_cnt[ui] + 1;
                        m_tgt[ui] = utg;
                    end else m_cnt[ui] = (m_cnt[ui] == 0) ? 0 : m_cnt[ui] - 1;
                end else if (ut) begin
                    m_valid[ui] = 1; m_tag[ui] = ut_tag; m_tgt[ui] = utg; m_cnt[ui] = WEAK_T;
                end
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic look(input logic [31:0] pc);
        step(pc, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic upd(input logic [31:0] lpc, input logic [31:0] pc, input bit t,
                       input logic [31:0] tg);
        step(lpc, 1, pc, t, tg, 0, 0, 0);
    endtask

`ifdef BP_STATS_EN
    task automatic check_stats(input string nm);
        checks++;
        if (stat_u !== 32'(m_upd) || stat_m !== 32'(m_mis)) begin
            errors++;
            $display("FAIL %s: got upd=%0d mis=%0d, expected upd=%0d mis=%0d",
                     nm, stat_u, stat_m, m_upd, m_mis);
        end
    endtask
`endif

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            checks++;
            if (bus.pred_hit !== e.hit || bus.pred_taken !== e.taken || bus.pred_target !== e.tgt) begin
                errors++;
                $display("FAIL lookup pc=%h: got hit=%b taken=%b tgt=%h, expected hit=%b taken=%b tgt=%h",
                         bus.lookup_pc, bus.pred_hit, bus.pred_taken, bus.pred_target,
                         e.hit, e.taken, e.tgt);
            end
        end
    end

    initial begin
        bus.lookup_pc = 0; bus.upd_valid = 0; bus.upd_pc = 0; bus.upd_taken = 0;
        bus.upd_target = 0; bus.upd_mispredict = 0; bus.inv_all = 0; reset = 1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;

        // Directed: allocation, counter walk, saturation
        look(32'h40);
        upd(32'h40, 32'h40, 1, 32'h100);
        upd(32'h40, 32'h40, 0, 32'h0);
        upd(32'h40, 32'h40, 0, 32'h0);
        upd(32'h40, 32'h40, 0, 32'h0);
        upd(32'h40, 32'h40, 1, 32'h104);
        upd(32'h40, 32'h40, 1, 32'h108);
        upd(32'h40, 32'h40, 1, 32'h10C);
        upd(32'h41, 32'h43, 1, 32'h110);
        look(32'h40);
        // Alias on the same set with a different tag
        upd(32'h40, 32'h440, 1, 32'h200);
        look(32'h40);
        look(32'h440);
        // Miss, not taken: no allocation
        upd(32'h80, 32'h80, 0, 32'h300);
        look(32'h80);
        // inv_all with a coincident update
        step(32'h440, 1, 32'h80, 1, 32'h300, 0, 1, 0);
        look(32'h440);
        look(32'h80);
        // Reset mid-stream with a coincident update
        upd(32'h40, 32'h40, 1, 32'h500);
        step(32'h40, 1, 32'h40, 1, 32'h600, 1, 0, 1);
        look(32'h40);
`ifdef BP_STATS_EN
        check_stats("stats_after_reset");
        for (int i = 0; i < 5; i++)
            step(32'h0, 1, 32'h40 + 32'(i * 4), 1, 32'h700, (i == 1 || i == 3), 0, 0);
        checks++;
        if (stat_u !== 32'd5 || stat_m !== 32'd2) begin
            errors++;
            $display("FAIL stats_5_2: got upd=%0d mis=%0d, expected upd=5 mis=2", stat_u, stat_m);
        end
        step(32'h0, 0, 0, 0, 0, 0, 0, 1);
        check_stats("stats_cleared");
`endif

        // Randomized traffic over a small PC pool to force hits and aliases
        for (int n = 0; n < 2000; n++) begin
            logic [31:0] lpc, upc, utg;
            lpc = ($urandom_range(0, 2) << 6) | ($urandom_range(0, 3) << 2) | $urandom_range(0, 3);
            upc = ($urandom_range(0, 2) << 6) | ($urandom_range(0, 3) << 2) | $urandom_range(0, 3);
            utg = $urandom;
            step(lpc, $urandom_range(0, 3) != 0, upc, $urandom_range(0, 1) == 1, utg,
                 $urandom_range(0, 3) == 0, $urandom_range(0, 63) == 0,
                 $urandom_range(0, 127) == 0);
`ifdef BP_STATS_EN
            check_stats("stats_random");
`endif
        end

        repeat (3) @(negedge clk);
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d predictions left unchecked, expected 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
